// File: rtl/bk_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bk_adder_pipe
// Description : Pipelined Brent-Kung prefix adder/subtractor with valid/ready
//               streams on input and output. WIDTH is a power of two (8..64),
//               PIPE selects 1..3 register stages (latency when not stalled).
//               Optional macro BK_ADDER_PIPE_SAT_EN: saturate s on signed
//               overflow (cout and ovf still report raw values).
// Revision    : 1.0 - initial release
// ============================================================================
module bk_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG = $clog2(WIDTH);

  generate
    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("bk_adder_pipe: WIDTH must be a power of two in 8..64");
    end
    if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
      $error("bk_adder_pipe: PIPE must be 1..3");
    end
  endgenerate

  // Up-sweep: at level l, node i = k*2^(l+1)-1 absorbs node i-2^l, so node i
  // ends up holding the group (G,P) of its aligned 2^(l+1)-bit block.
  function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] p_i,
                                                  input logic [WIDTH-1:0] g_i);
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    gg = g_i;
    pp = p_i;
    for (int l = 0; l < LOG; l++) begin
      for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    return {pp, gg};
  endfunction

  // Down-sweep: fill in the remaining nodes from coarse to fine stride. Since
  // carry-in is folded into g[0], every resulting G[i] is the carry out of bit i.
  function automatic logic [WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] p_u,
                                                  input logic [WIDTH-1:0] g_u);
    logic [WIDTH-1:0] gg;
    gg = g_u;
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
        gg[i] = gg[i] | (p_u[i] & gg[i - (1 << l)]);
      end
    end
    return gg;
  endfunction

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0;

  // Operand prep: invert B for subtract, fold carry/borrow-in into g[0].
  always_comb begin
    b       = sub ? ~x2 : x2;
    c0      = cin ^ sub;
    p_in    = x1 ^ b;
    g_in    = x1 & b;
    g_in[0] = g_in[0] | (p_in[0] & c0);
  end

  // Signals feeding the output stage from whichever front end is built.
  logic             os_valid;
  logic             os_c0;
  logic [WIDTH-1:0] os_p;
  logic [WIDTH-1:0] os_gu;
  logic [WIDTH-1:0] os_pu;
  logic             out_en;

  logic             out_valid_q, out_valid_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] carry;

  assign out_en = out_ready | ~out_valid_q;

  generate
    if (PIPE == 3) begin : g_pipe3
      logic             v1_q, v1_d, v2_q, v2_d;
      logic             c01_q, c01_d, c02_q, c02_d;
      logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
      logic [WIDTH-1:0] p2_q, p2_d, gu2_q, gu2_d, pu2_q, pu2_d;
      logic [2*WIDTH-1:0] up;
      logic             en1, en2;

      // Stage 1 holds p/g/c0; stage 2 holds the up-sweep result.
      always_comb begin
        en2   = ~v2_q | out_en;
        en1   = ~v1_q | en2;
        up    = up_sweep(p1_q, g1_q);
        v1_d  = en1 ? in_valid : v1_q;
        p1_d  = p1_q;
        g1_d  = g1_q;
        c01_d = c01_q;
        if (en1 && in_valid) begin
          p1_d  = p_in;
          g1_d  = g_in;
          c01_d = c0;
        end
        v2_d  = en2 ? v1_q : v2_q;
        p2_d  = p2_q;
        c02_d = c02_q;
        pu2_d = pu2_q;
        gu2_d = gu2_q;
        if (en2 && v1_q) begin
          p2_d  = p1_q;
          c02_d = c01_q;
          pu2_d = up[2*WIDTH-1:WIDTH];
          gu2_d = up[WIDTH-1:0];
        end
      end

      // Front-end stage registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1_q  <= 1'b0;
          v2_q  <= 1'b0;
          c01_q <= 1'b0;
          c02_q <= 1'b0;
          p1_q  <= '0;
          g1_q  <= '0;
          p2_q  <= '0;
          gu2_q <= '0;
          pu2_q <= '0;
        end else begin
          v1_q  <= v1_d;
          v2_q  <= v2_d;
          c01_q <= c01_d;
          c02_q <= c02_d;
          p1_q  <= p1_d;
          g1_q  <= g1_d;
          p2_q  <= p2_d;
          gu2_q <= gu2_d;
          pu2_q <= pu2_d;
        end
      end

      assign in_ready = en1;
      assign os_valid = v2_q;
      assign os_c0    = c02_q;
      assign os_p     = p2_q;
      assign os_gu    = gu2_q;
      assign os_pu    = pu2_q;
    end else if (PIPE == 2) begin : g_pipe2
      logic             v1_q, v1_d, c01_q, c01_d;
      logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
      logic [2*WIDTH-1:0] up;
      logic             en1;

      // Single front-end stage holding p/g/c0; up-sweep stays combinational.
      always_comb begin
        en1   = ~v1_q | out_en;
        up    = up_sweep(p1_q, g1_q);
        v1_d  = en1 ? in_valid : v1_q;
        p1_d  = p1_q;
        g1_d  = g1_q;
        c01_d = c01_q;
        if (en1 && in_valid) begin
          p1_d  = p_in;
          g1_d  = g_in;
          c01_d = c0;
        end
      end

      // Front-end stage register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1_q  <= 1'b0;
          c01_q <= 1'b0;
          p1_q  <= '0;
          g1_q  <= '0;
        end else begin
          v1_q  <= v1_d;
          c01_q <= c01_d;
          p1_q  <= p1_d;
          g1_q  <= g1_d;
        end
      end

      assign in_ready = en1;
      assign os_valid = v1_q;
      assign os_c0    = c01_q;
      assign os_p     = p1_q;
      assign os_gu    = up[WIDTH-1:0];
      assign os_pu    = up[2*WIDTH-1:WIDTH];
    end else begin : g_pipe1
      logic [2*WIDTH-1:0] up;

      assign up       = up_sweep(p_in, g_in);
      assign in_ready = out_en;
      assign os_valid = in_valid;
      assign os_c0    = c0;
      assign os_p     = p_in;
      assign os_gu    = up[WIDTH-1:0];
      assign os_pu    = up[2*WIDTH-1:WIDTH];
    end
  endgenerate

  // Output stage: down-sweep, sum, carry/overflow, optional saturation.
  always_comb begin
    carry       = down_sweep(os_pu, os_gu);
    out_valid_d = out_en ? os_valid : out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (out_en && os_valid) begin
      s_d    = os_p ^ {carry[WIDTH-2:0], os_c0};
      cout_d = carry[WIDTH-1];
      ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
`ifdef BK_ADDER_PIPE_SAT_EN
      // On overflow the operand MSBs agree, so a carry into the MSB means both
      // were 0 (positive overflow); otherwise both were 1 (negative overflow).
      if (ovf_d) begin
        s_d = carry[WIDTH-2] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end
`endif
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
